// File: rtl/dag_addr_gen_pkg.sv
// Shared types and constants for the data address generator.
package dag_addr_gen_pkg;

  localparam int AW   = 16;
  localparam int NREG = 8;
  localparam int IW   = 3;

  typedef logic [AW-1:0] word_t;
  typedef logic [IW-1:0] idx_t;

  typedef enum logic [1:0] {
    BANK_I = 2'b00,
    BANK_M = 2'b01,
    BANK_L = 2'b10,
    BANK_B = 2'b11
  } bank_e;

endpackage

// File: rtl/dag_circ_mod.sv
// Combinational next-index computation with optional circular-buffer wrap.
module dag_circ_mod
  import dag_addr_gen_pkg::*;
(
  input  word_t idx,
  input  word_t mdf,
  input  word_t len,
  input  word_t base,
  output word_t nxt
);

  word_t         sum;
  logic [AW:0]   sum_x;
  logic [AW:0]   top_x;
  logic [AW:0]   base_x;

  // Bounds are compared at AW+1 bits so base+len past 0xFFFF does not alias.
  always_comb begin
    sum    = idx + mdf;
    sum_x  = {1'b0, sum};
    top_x  = {1'b0, base} + {1'b0, len};
    base_x = {1'b0, base};
    nxt    = sum;
    if (len != '0) begin
      if (sum_x >= top_x) begin
        nxt = sum - len;
      end else if (sum_x < base_x) begin
        nxt = sum + len;
      end
    end
  end

endmodule

// File: rtl/dag_addr_gen.sv
// Data address generator: I/M/L/B register banks, pre/post-modify addressing,
// registered address outputs and ureg read/write access.
module dag_addr_gen
  import dag_addr_gen_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          ps_dg_en,
  input  logic          ps_dg_dgsclt,
  input  logic          ps_dg_mdfy,
  input  logic [2:0]    ps_dg_iadd,
  input  logic [2:0]    ps_dg_madd,
  input  logic          ps_dg_wrt_en,
  input  logic [4:0]    ps_dg_wrt_add,
  input  logic [4:0]    ps_dg_rd_add,
  input  logic [15:0]   bc_dt,
  output logic [15:0]   dg_dm_add,
  output logic          dg_dm_vld,
  output logic [15:0]   dg_ps_add,
  output logic          dg_ps_vld,
  output logic [15:0]   dg_bc_dt
);

  word_t i_q [NREG];
  word_t m_q [NREG];
  word_t l_q [NREG];
  word_t b_q [NREG];

  word_t cur_i;
  word_t cur_m;
  word_t cur_l;
  word_t cur_b;
  word_t nxt_i;
  word_t addr;
  bank_e wr_bank;
  idx_t  wr_idx;
  bank_e rd_bank;
  idx_t  rd_idx;
  logic  post_upd;

  assign cur_i    = i_q[ps_dg_iadd];
  assign cur_m    = m_q[ps_dg_madd];
  assign cur_l    = l_q[ps_dg_iadd];
  assign cur_b    = b_q[ps_dg_iadd];
  assign addr     = ps_dg_mdfy ? (cur_i + cur_m) : cur_i;
  assign post_upd = ps_dg_en && !ps_dg_mdfy;
  assign wr_bank  = bank_e'(ps_dg_wrt_add[4:3]);
  assign wr_idx   = ps_dg_wrt_add[2:0];
  assign rd_bank  = bank_e'(ps_dg_rd_add[4:3]);
  assign rd_idx   = ps_dg_rd_add[2:0];

  dag_circ_mod u_circ (
    .idx  (cur_i),
    .mdf  (cur_m),
    .len  (cur_l),
    .base (cur_b),
    .nxt  (nxt_i)
  );

  // A ureg write to In or Bn takes priority over the post-modify update of In.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < NREG; n++) begin
        i_q[n] <= '0;
        m_q[n] <= '0;
        l_q[n] <= '0;
        b_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NREG; n++) begin
        if (ps_dg_wrt_en && wr_idx == idx_t'(n) &&
            (wr_bank == BANK_I || wr_bank == BANK_B)) begin
          i_q[n] <= bc_dt;
        end else if (post_upd && ps_dg_iadd == idx_t'(n)) begin
          i_q[n] <= nxt_i;
        end
        if (ps_dg_wrt_en && wr_idx == idx_t'(n) && wr_bank == BANK_M) begin
          m_q[n] <= bc_dt;
        end
        if (ps_dg_wrt_en && wr_idx == idx_t'(n) && wr_bank == BANK_L) begin
          l_q[n] <= bc_dt;
        end
        if (ps_dg_wrt_en && wr_idx == idx_t'(n) && wr_bank == BANK_B) begin
          b_q[n] <= bc_dt;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dg_dm_add <= '0;
      dg_ps_add <= '0;
      dg_dm_vld <= 1'b0;
      dg_ps_vld <= 1'b0;
    end else begin
      dg_dm_vld <= ps_dg_en && !ps_dg_dgsclt;
      dg_ps_vld <= ps_dg_en && ps_dg_dgsclt;
      if (ps_dg_en && !ps_dg_dgsclt) begin
        dg_dm_add <= addr;
      end
      if (ps_dg_en && ps_dg_dgsclt) begin
        dg_ps_add <= addr;
      end
    end
  end

  always_comb begin
    dg_bc_dt = '0;
    case (rd_bank)
      BANK_I:  dg_bc_dt = i_q[rd_idx];
      BANK_M:  dg_bc_dt = m_q[rd_idx];
      BANK_L:  dg_bc_dt = l_q[rd_idx];
      BANK_B:  dg_bc_dt = b_q[rd_idx];
      default: dg_bc_dt = '0;
    endcase
  end

endmodule

// File: tb/tb_dag_addr_gen.sv
// Bench for dag_addr_gen: directed scenarios plus random traffic against an
// array-based reference model, with an expected-address queue and monitor.
module tb_dag_addr_gen;

  logic        clk;
  logic        rst;
  logic        ps_dg_en;
  logic        ps_dg_dgsclt;
  logic        ps_dg_mdfy;
  logic [2:0]  ps_dg_iadd;
  logic [2:0]  ps_dg_madd;
  logic        ps_dg_wrt_en;
  logic [4:0]  ps_dg_wrt_add;
  logic [4:0]  ps_dg_rd_add;
  logic [15:0] bc_dt;
  logic [15:0] dg_dm_add;
  logic        dg_dm_vld;
  logic [15:0] dg_ps_add;
  logic        dg_ps_vld;
  logic [15:0] dg_bc_dt;

  dag_addr_gen dut (
    .clk           (clk),
    .rst           (rst),
    .ps_dg_en      (ps_dg_en),
    .ps_dg_dgsclt  (ps_dg_dgsclt),
    .ps_dg_mdfy    (ps_dg_mdfy),
    .ps_dg_iadd    (ps_dg_iadd),
    .ps_dg_madd    (ps_dg_madd),
    .ps_dg_wrt_en  (ps_dg_wrt_en),
    .ps_dg_wrt_add (ps_dg_wrt_add),
    .ps_dg_rd_add  (ps_dg_rd_add),
    .bc_dt         (bc_dt),
    .dg_dm_add     (dg_dm_add),
    .dg_dm_vld     (dg_dm_vld),
    .dg_ps_add     (dg_ps_add),
    .dg_ps_vld     (dg_ps_vld),
    .dg_bc_dt      (dg_bc_dt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  int mi [8];
  int mm [8];
  int ml [8];
  int mb [8];
  logic [16:0] exp_q [$];   // {dst, addr}, dst 1 = program memory
  int exp_dm;
  int exp_ps;
  int n_vec;
  int n_miss;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int circ_next(input int i, input int m, input int l, input int b);
    int s;
    s = (i + m) & 'hFFFF;
    if (l == 0) return s;
    if (s >= b + l) return (s - l) & 'hFFFF;
    if (s < b) return (s + l) & 'hFFFF;
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    ps_dg_en      = 1'b0;
    ps_dg_dgsclt  = 1'b0;
    ps_dg_mdfy    = 1'b0;
    ps_dg_iadd    = '0;
    ps_dg_madd    = '0;
    ps_dg_wrt_en  = 1'b0;
    ps_dg_wrt_add = '0;
    bc_dt         = '0;
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the next.
  task automatic issue(input logic en, input logic sel, input logic mdfy,
                       input int iadd, input int madd,
                       input logic we, input int wadd, input int wdata);
    int addr;
    int nxt;
    ps_dg_en      = en;
    ps_dg_dgsclt  = sel;
    ps_dg_mdfy    = mdfy;
    ps_dg_iadd    = 3'(iadd);
    ps_dg_madd    = 3'(madd);
    ps_dg_wrt_en  = we;
    ps_dg_wrt_add = 5'(wadd);
    bc_dt         = 16'(wdata);
    addr = mdfy ? ((mi[iadd] + mm[madd]) & 'hFFFF) : mi[iadd];
    nxt  = circ_next(mi[iadd], mm[madd], ml[iadd], mb[iadd]);
    if (en) exp_q.push_back({sel, 16'(addr)});
    @(posedge clk);
    #1;
    if (en && !mdfy) mi[iadd] = nxt;
    if (we) begin
      case (wadd >> 3)
        0: mi[wadd & 7] = wdata;
        1: mm[wadd & 7] = wdata;
        2: ml[wadd & 7] = wdata;
        default: begin
          mb[wadd & 7] = wdata;
          mi[wadd & 7] = wdata;
        end
      endcase
    end
    idle_inputs();
  endtask

  task automatic write_reg(input int bank, input int idx, input int data);
    issue(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, bank * 8 + idx, data);
  endtask

  task automatic check_reg(input int bank, input int idx);
    int exp;
    ps_dg_rd_add = 5'(bank * 8 + idx);
    #1;
    case (bank)
      0: exp = mi[idx];
      1: exp = mm[idx];
      2: exp = ml[idx];
      default: exp = mb[idx];
    endcase
    chk($sformatf("ureg_rd[%0d][%0d]", bank, idx), int'(dg_bc_dt), exp);
  endtask

  task automatic check_all_regs();
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 8; k++)
        check_reg(b, k);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (dg_dm_vld || dg_ps_vld) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_vld", {30'd0, dg_ps_vld, dg_dm_vld}, 0);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          if (e[16]) exp_ps = int'(e[15:0]);
          else       exp_dm = int'(e[15:0]);
          chk("vld_route", {30'd0, dg_ps_vld, dg_dm_vld}, e[16] ? 2 : 1);
          chk("dm_add", int'(dg_dm_add), exp_dm);
          chk("ps_add", int'(dg_ps_add), exp_ps);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int bank;
    int wdata;
    n_vec = 0;
    n_miss = 0;
    exp_dm = 0;
    exp_ps = 0;
    for (int k = 0; k < 8; k++) begin
      mi[k] = 0; mm[k] = 0; ml[k] = 0; mb[k] = 0;
    end
    idle_inputs();
    ps_dg_rd_add = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dm_add", int'(dg_dm_add), 0);
    chk("rst_ps_add", int'(dg_ps_add), 0);
    chk("rst_vld", {30'd0, dg_ps_vld, dg_dm_vld}, 0);
    check_all_regs();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Linear post-modify to data memory
    write_reg(0, 0, 'h0100);
    write_reg(1, 0, 'h0004);
    write_reg(2, 0, 'h0000);
    repeat (3) issue(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
    check_reg(0, 0);
    chk("lin_i0_final", int'(dg_bc_dt), 'h010C);

    // Circular wrap, B write seeds I
    write_reg(3, 1, 'h0200);
    write_reg(2, 1, 4);
    write_reg(1, 1, 3);
    check_reg(0, 1);
    repeat (4) issue(1'b1, 1'b0, 1'b0, 1, 1, 1'b0, 0, 0);
    check_reg(0, 1);
    chk("circ_i1_final", int'(dg_bc_dt), 'h0200);

    // Negative modify wrapping below base
    write_reg(0, 1, 'h0200);
    write_reg(1, 1, 'hFFFF);
    issue(1'b1, 1'b0, 1'b0, 1, 1, 1'b0, 0, 0);
    check_reg(0, 1);
    chk("neg_i1_final", int'(dg_bc_dt), 'h0203);

    // Pre-modify to program memory
    write_reg(0, 3, 'h0010);
    write_reg(1, 3, 'h0020);
    issue(1'b1, 1'b1, 1'b1, 3, 3, 1'b0, 0, 0);
    check_reg(0, 3);
    chk("pre_i3_final", int'(dg_bc_dt), 'h0010);

    // Write beats post-modify: explicit I write, then B-induced I write
    write_reg(0, 4, 'h0050);
    write_reg(1, 4, 1);
    issue(1'b1, 1'b0, 1'b0, 4, 4, 1'b1, 4, 'h0999);
    check_reg(0, 4);
    chk("coll_i4_final", int'(dg_bc_dt), 'h0999);
    write_reg(0, 5, 'h0070);
    write_reg(1, 5, 2);
    issue(1'b1, 1'b1, 1'b0, 5, 5, 1'b1, 24 + 5, 'h0ABC);
    check_reg(0, 5);
    check_reg(3, 5);

    // Randomized traffic; M kept small and L either 0 or larger than |M|
    for (int t = 0; t < 400; t++) begin
      logic we;
      int wadd;
      we = ($urandom_range(0, 3) == 0);
      wadd = $urandom_range(0, 31);
      bank = wadd >> 3;
      if (bank == 1)      wdata = ($urandom_range(0, 14) - 7) & 'hFFFF;
      else if (bank == 2) wdata = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(8, 15);
      else                wdata = $urandom_range(0, 'hFFFF);
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7), $urandom_range(0, 7), we, wadd, wdata);
      if ((t % 8) == 7) check_reg($urandom_range(0, 3), $urandom_range(0, 7));
    end
    check_all_regs();

    // Mid-run reset with a request pending
    write_reg(0, 2, 'h0040);
    repeat (2) @(posedge clk);
    #1;
    ps_dg_en   = 1'b1;
    ps_dg_iadd = 3'd2;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      mi[k] = 0; mm[k] = 0; ml[k] = 0; mb[k] = 0;
    end
    exp_dm = 0;
    exp_ps = 0;
    @(posedge clk);
    #1;
    idle_inputs();
    chk("mid_rst_dm_add", int'(dg_dm_add), 0);
    chk("mid_rst_ps_add", int'(dg_ps_add), 0);
    chk("mid_rst_vld", {30'd0, dg_ps_vld, dg_dm_vld}, 0);
    check_all_regs();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // One request after reset to confirm the block runs again
    write_reg(1, 6, 'h0005);
    write_reg(0, 6, 'h1234);
    issue(1'b1, 1'b0, 1'b1, 6, 6, 1'b0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dag_addr_gen.md
Name: dag_addr_gen

Overview:
Data address generator sitting directly downstream of the program sequencer. It consumes the sequencer's DAG control fields and produces memory addresses. It holds eight index (I), modify (M), length (L) and base (B) registers and performs pre-/post-modify addressing with circular-buffer wrap. Generated addresses drive the data memory address bus or the program-memory address mux (dg_ps_add). The DAG registers are also readable and writable as universal registers over the bus-connect data path.

Parameters:
AW, 16, address and data width of all DAG registers
NREG, 8, number of registers per I/M/L/B bank (index width 3)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
ps_dg_en  in  1  address-generation request this cycle (already condition-qualified)
ps_dg_dgsclt  in  1  destination select: 0 = data memory, 1 = program memory
ps_dg_mdfy  in  1  1 = pre-modify (no I update), 0 = post-modify (I updated)
ps_dg_iadd  in  3  I register index
ps_dg_madd  in  3  M register index
ps_dg_wrt_en  in  1  ureg write strobe into DAG space
ps_dg_wrt_add  in  5  ureg write address: [4:3] bank (00=I,01=M,10=L,11=B), [2:0] index
ps_dg_rd_add  in  5  ureg read address, same encoding
bc_dt  in  16  ureg write data from bus connect
dg_dm_add  out  16  data memory address
dg_dm_vld  out  1  dg_dm_add valid strobe
dg_ps_add  out  16  program-memory address to sequencer mux
dg_ps_vld  out  1  dg_ps_add valid strobe
dg_bc_dt  out  16  ureg read data to bus connect

Behaviour:
- Reset (rst low, async): all I/M/L/B = 0; dg_dm_add = dg_ps_add = 0; dg_dm_vld = dg_ps_vld = 0. A reset mid-operation discards any pending update.
- Address generation on a clk edge with ps_dg_en=1:
  - M is treated as signed two's complement 16-bit.
  - Pre-modify: addr = I + M, mod 2^16. No circular wrap. I is unchanged.
  - Post-modify: addr = I. I is updated to nxt.
  - nxt when L = 0: I + M, mod 2^16 (linear).
  - nxt when L != 0: s = I + M. If s >= B + L, nxt = s - L. Else if s < B, nxt = s + L. Else nxt = s.
  - All compares are unsigned 17-bit, to avoid wrap aliasing.
  - |M| > L is undefined (single correction only).
- Output routing:
  - addr is registered into dg_dm_add when dgsclt=0, or into dg_ps_add when dgsclt=1. The other bus holds its previous value.
  - The matching vld is high for exactly one cycle. Latency is 1 clk from request.
- With ps_dg_en=0: both vld go low, address outputs hold, no I update.
- Ureg write (ps_dg_wrt_en=1): register[wrt_add] <= bc_dt at the clk edge.
  - A write to Bn also loads In <= bc_dt on the same edge.
- Simultaneous write and post-modify to the same I: the ureg write (explicit or B-induced) wins.
  - Address generation that cycle still uses the old I value.
- Read: dg_bc_dt is the combinational current register value at ps_dg_rd_add. There is no write bypass.
- Back-to-back requests: each cycle's request sees the I value updated by the previous cycle's post-modify (read-after-update through the register, no stall).

Decomposition:
- Shared package: bank encodings (BANK_I=2'b00, BANK_M=2'b01, BANK_L=2'b10, BANK_B=2'b11), AW, NREG.
- One sub-module, dag_circ_mod: purely combinational. Takes I, M, L, B and returns nxt per the circular rule. Keeps the wrap arithmetic separately testable.
- The register file, write arbitration and output registers stay in the top level.

Test Plan:
- Reset: assert rst mid-run with I2=0x0040 -> all registers read 0, both vld=0, address outputs 0.
- Linear post-modify: I0=0x0100, M0=0x0004, L0=0; three requests with dgsclt=0, mdfy=0 -> dg_dm_add = 0x0100, 0x0104, 0x0108 on consecutive cycles, I0 ends 0x010C, dg_dm_vld high 3 cycles.
- Circular wrap: write B1=0x0200 (I1 auto=0x0200), L1=4, M1=3; four post-modify requests -> addresses 0x0200, 0x0203, 0x0202, 0x0201; I1 ends 0x0200.
- Negative modify with wrap: B1=0x0200, L1=4, I1=0x0200, M1=0xFFFF (-1) -> addr 0x0200, I1 becomes 0x0203.
- Pre-modify to PM: I3=0x0010, M3=0x0020, dgsclt=1, mdfy=1 -> dg_ps_add=0x0030 one cycle later, dg_ps_vld pulse, I3 stays 0x0010, dg_dm_add unchanged.
- Write/update collision: post-modify on I4=0x0050, M4=1 while ureg write I4<=0x0999 on the same edge -> addr output 0x0050, I4 reads 0x0999.
